// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default widths, loader state
// encodings and the width of the RUN cycle counter.
package program_loader_pkg;

  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_MEM_ADDR_SIZE = 8;
  localparam int CYCLE_W           = 16;

  typedef enum logic [2:0] {
    LDR_LOAD = 3'd0,
    LDR_RUN  = 3'd1,
    LDR_DUMP = 3'd2,
    LDR_DONE = 3'd3
  } ldr_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host-side streams of the loader: program load stream in, memory dump stream out.
// master = host, slave = program_loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/program_loader_mem_port_mux.sv
// Selects who drives the memory port: the load stream in LOAD, the CPU in RUN,
// the dump address generator in DUMP, nobody in DONE.
module mem_port_mux
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE
) (
  input  ldr_state_t               state,
  input  logic [MEM_ADDR_SIZE-1:0] load_addr,
  input  logic [WORD_SIZE-1:0]     load_data,
  input  logic                     load_write,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0]     cpu_write_data,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [MEM_ADDR_SIZE-1:0] dump_addr,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write
);

  // Source select by loader state; idle port (no read, no write) by default
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (state)
      LDR_LOAD: begin
        mem_address    = load_addr;
        mem_write_data = load_data;
        mem_write      = load_write;
      end
      LDR_RUN: begin
        mem_address    = cpu_address;
        mem_write_data = cpu_write_data;
        mem_read       = cpu_read;
        mem_write      = cpu_write;
      end
      LDR_DUMP: begin
        mem_address = dump_addr;
        mem_read    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: streams an image into memory with the CPU held in reset,
// runs the CPU until it halts or times out, then streams all of memory back.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
  parameter int MAX_CYCLES    = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  program_loader_if.slave          host,
  input  logic                     restart,
  output logic                     cpu_reset,
  output logic                     cpu_execute,
  input  logic                     cpu_halted,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_mem_address,
  input  logic [WORD_SIZE-1:0]     cpu_mem_write_data,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  output logic [WORD_SIZE-1:0]     cpu_mem_read_data,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic [2:0]               state,
  output logic                     done,
  output logic                     timeout,
  output logic                     overflow,
  output logic [CYCLE_W-1:0]       cycle_count
);

  localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [CYCLE_W-1:0]       LIMIT     = CYCLE_W'(MAX_CYCLES - 1);

  ldr_state_t               st, st_nxt;
  logic [MEM_ADDR_SIZE-1:0] load_addr, dump_addr;
  logic                     load_fire, dump_fire, tmo_hit;

  // in_ready is 1 throughout LOAD, so a load handshake is just in_valid there
  assign load_fire = (st == LDR_LOAD) && host.in_valid;
  assign dump_fire = (st == LDR_DUMP) && host.out_ready;
  // halted has priority over the timeout on the same cycle
  assign tmo_hit   = (st == LDR_RUN) && !cpu_halted && (cycle_count == LIMIT);

  assign state             = st;
  assign cpu_mem_read_data = mem_read_data;
  assign host.out_data     = mem_read_data;

  // State register
  always_ff @(posedge clock) begin
    if (reset) st <= LDR_LOAD;
    else       st <= st_nxt;
  end

  // Next state and per-state handshake / CPU control outputs
  always_comb begin
    st_nxt        = st;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    host.out_last  = 1'b0;
    done          = 1'b0;
    cpu_execute   = 1'b0;
    cpu_reset     = reset || (st == LDR_LOAD) || (st == LDR_DONE);
    case (st)
      LDR_LOAD: begin
        host.in_ready = 1'b1;
        if (load_fire && (host.in_last || load_addr == LAST_ADDR)) st_nxt = LDR_RUN;
      end
      LDR_RUN: begin
        // the counter only leaves 0 after the first RUN cycle and never wraps
        cpu_execute = (cycle_count == '0);
        if (cpu_halted || tmo_hit) st_nxt = LDR_DUMP;
      end
      LDR_DUMP: begin
        host.out_valid = 1'b1;
        host.out_last  = (dump_addr == LAST_ADDR);
        if (dump_fire && dump_addr == LAST_ADDR) st_nxt = LDR_DONE;
      end
      LDR_DONE: begin
        done = 1'b1;
        if (restart) st_nxt = LDR_LOAD;
      end
      default: st_nxt = LDR_LOAD;
    endcase
  end

  // Address counters, RUN cycle counter and sticky status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      load_addr   <= '0;
      dump_addr   <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (st)
        LDR_LOAD: if (load_fire) begin
          // the final address holds rather than wrapping onto word 0
          if (load_addr != LAST_ADDR) load_addr <= load_addr + 1'b1;
          else if (!host.in_last)     overflow  <= 1'b1;
        end
        LDR_RUN: begin
          if (tmo_hit)                                 timeout     <= 1'b1;
          else if (!cpu_halted && cycle_count != '1)   cycle_count <= cycle_count + 1'b1;
        end
        LDR_DUMP: if (dump_fire) dump_addr <= (dump_addr == LAST_ADDR) ? '0 : dump_addr + 1'b1;
        LDR_DONE: if (restart) begin
          load_addr   <= '0;
          dump_addr   <= '0;
          cycle_count <= '0;
          timeout     <= 1'b0;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mem_port_mux #(
    .WORD_SIZE     (WORD_SIZE),
    .MEM_ADDR_SIZE (MEM_ADDR_SIZE)
  ) u_mux (
    .state          (st),
    .load_addr      (load_addr),
    .load_data      (host.in_data),
    .load_write     (load_fire),
    .cpu_address    (cpu_mem_address),
    .cpu_write_data (cpu_mem_write_data),
    .cpu_read       (cpu_mem_read),
    .cpu_write      (cpu_mem_write),
    .dump_addr      (dump_addr),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

endmodule
